// File: rtl/ctrl_pc_unit_if.sv
// Fetch-side control bundle for ctrl_pc_unit: stall/redirect requests in, registered PC and RAS status out.
interface ctrl_pc_unit_if #(
    parameter int PROG_CTR_WID = 10,
    parameter int RAS_DEPTH    = 4
);
    logic                             stall_IF;
    logic                             branch_taken_EX;
    logic                             call_EX;
    logic                             ret_EX;
    logic [PROG_CTR_WID-1:0]          nxt_prog_ctr_EX;
    logic [PROG_CTR_WID-1:0]          link_addr_EX;
    logic [PROG_CTR_WID-1:0]          prog_ctr;
    logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count;
    logic                             ras_ovf;
    logic                             ras_unf;

    modport master (
        output stall_IF, branch_taken_EX, call_EX, ret_EX, nxt_prog_ctr_EX, link_addr_EX,
        input  prog_ctr, ras_count, ras_ovf, ras_unf
    );

    modport slave (
        input  stall_IF, branch_taken_EX, call_EX, ret_EX, nxt_prog_ctr_EX, link_addr_EX,
        output prog_ctr, ras_count, ras_ovf, ras_unf
    );
endinterface

// File: rtl/ctrl_pc_unit.sv
// Program counter with stall hold, EX redirects and a circular return-address stack.
// Define CTRL_PC_RAS_EN to build the RAS; otherwise call/return act as plain branches and RAS status reads 0.
module ctrl_pc_unit #(
    parameter int PROG_CTR_WID = 10,
    parameter int RESET_VEC    = 0,
    parameter int RAS_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    ctrl_pc_unit_if.slave bus
);
    localparam int CNT_WID = $clog2(RAS_DEPTH + 1);

    logic [PROG_CTR_WID-1:0] pc_q;
    logic [PROG_CTR_WID-1:0] pc_inc;

    assign pc_inc       = pc_q + PROG_CTR_WID'(1);
    assign bus.prog_ctr = pc_q;

`ifdef CTRL_PC_RAS_EN
    localparam int PTR_WID = $clog2(RAS_DEPTH);

    logic [PROG_CTR_WID-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_WID-1:0]      ptr_q;
    logic [PTR_WID-1:0]      ptr_dec;
    logic [CNT_WID-1:0]      cnt_q;
    logic                    ovf_q;
    logic                    unf_q;
    logic                    ras_full;
    logic                    ras_empty;
    logic                    push;

    assign ptr_dec   = ptr_q - PTR_WID'(1);
    assign ras_full  = (cnt_q == CNT_WID'(RAS_DEPTH));
    assign ras_empty = (cnt_q == '0);
    // A simultaneous return wins, so the call's push is dropped.
    assign push      = bus.call_EX && !bus.ret_EX && !reset;

    // ptr_q is the next free slot; the top of stack is ptr_q-1, wrapping modulo RAS_DEPTH.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ptr_q] <= bus.link_addr_EX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= PROG_CTR_WID'(RESET_VEC);
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.ret_EX) begin
            if (ras_empty) begin
                pc_q  <= pc_inc;
                unf_q <= 1'b1;
            end else begin
                pc_q  <= ras_mem[ptr_dec];
                ptr_q <= ptr_dec;
                cnt_q <= cnt_q - CNT_WID'(1);
            end
        end else if (bus.call_EX) begin
            pc_q  <= bus.nxt_prog_ctr_EX;
            ptr_q <= ptr_q + PTR_WID'(1);
            if (ras_full) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_WID'(1);
            end
        end else if (bus.branch_taken_EX) begin
            pc_q <= bus.nxt_prog_ctr_EX;
        end else if (!bus.stall_IF) begin
            pc_q <= pc_inc;
        end
    end

    assign bus.ras_count = cnt_q;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
`else
    logic unused_link;

    assign unused_link = ^bus.link_addr_EX;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PROG_CTR_WID'(RESET_VEC);
        end else if (bus.ret_EX || bus.call_EX || bus.branch_taken_EX) begin
            pc_q <= bus.nxt_prog_ctr_EX;
        end else if (!bus.stall_IF) begin
            pc_q <= pc_inc;
        end
    end

    assign bus.ras_count = CNT_WID'(0);
    assign bus.ras_ovf   = 1'b0;
    assign bus.ras_unf   = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_pc_unit.sv
// Directed bench for ctrl_pc_unit; RAS checks are selected by CTRL_PC_RAS_EN to match the build.
module tb_ctrl_pc_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    ctrl_pc_unit_if #(.PROG_CTR_WID(10), .RAS_DEPTH(4)) bus ();

    ctrl_pc_unit #(
        .PROG_CTR_WID (10),
        .RESET_VEC    (0),
        .RAS_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, sample 1 ns after the edge, then return inputs to idle.
    task automatic cyc(input logic s, input logic b, input logic c, input logic r,
                       input logic [9:0] nxt, input logic [9:0] link);
        bus.stall_IF        = s;
        bus.branch_taken_EX = b;
        bus.call_EX         = c;
        bus.ret_EX          = r;
        bus.nxt_prog_ctr_EX = nxt;
        bus.link_addr_EX    = link;
        @(posedge clk);
        #1;
        bus.stall_IF        = 1'b0;
        bus.branch_taken_EX = 1'b0;
        bus.call_EX         = 1'b0;
        bus.ret_EX          = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.stall_IF        = 1'b0;
        bus.branch_taken_EX = 1'b0;
        bus.call_EX         = 1'b0;
        bus.ret_EX          = 1'b0;
        bus.nxt_prog_ctr_EX = '0;
        bus.link_addr_EX    = '0;

        do_reset();
        check("reset_pc",  bus.prog_ctr,  32'h0);
        check("reset_cnt", bus.ras_count, 32'h0);
        check("reset_ovf", bus.ras_ovf,   32'h0);
        check("reset_unf", bus.ras_unf,   32'h0);

        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 0, 10'h0, 10'h0);
            check($sformatf("run_%0d", i), bus.prog_ctr, i);
        end

        cyc(0, 1, 0, 0, 10'h3FF, 10'h0);
        check("preload_3ff", bus.prog_ctr, 32'h3FF);
        cyc(0, 0, 0, 0, 10'h0, 10'h0);
        check("wrap_000", bus.prog_ctr, 32'h000);

        cyc(0, 1, 0, 0, 10'h020, 10'h0);
        check("br_020", bus.prog_ctr, 32'h020);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 10'h0, 10'h0);
            check($sformatf("stall_%0d", i), bus.prog_ctr, 32'h020);
        end
        cyc(1, 1, 0, 0, 10'h100, 10'h0);
        check("stall_br_100", bus.prog_ctr, 32'h100);
        cyc(0, 0, 0, 0, 10'h0, 10'h0);
        check("after_br_101", bus.prog_ctr, 32'h101);

`ifdef CTRL_PC_RAS_EN
        cyc(0, 0, 1, 0, 10'h050, 10'h011);
        check("nest_pc1",  bus.prog_ctr,  32'h050);
        check("nest_cnt1", bus.ras_count, 32'd1);
        cyc(0, 0, 1, 0, 10'h080, 10'h052);
        check("nest_pc2",  bus.prog_ctr,  32'h080);
        check("nest_cnt2", bus.ras_count, 32'd2);
        cyc(0, 1, 0, 1, 10'h3AA, 10'h0);
        check("nest_pc3",  bus.prog_ctr,  32'h052);
        check("nest_cnt3", bus.ras_count, 32'd1);
        cyc(0, 0, 0, 1, 10'h0, 10'h0);
        check("nest_pc4",  bus.prog_ctr,  32'h011);
        check("nest_cnt4", bus.ras_count, 32'd0);

        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 1, 0, 10'h200 + 10'(i), 10'(i));
        end
        check("ovf_pc",  bus.prog_ctr,  32'h205);
        check("ovf_cnt", bus.ras_count, 32'd4);
        check("ovf_flag", bus.ras_ovf,  32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 10'h0, 10'h0);
            check($sformatf("ovf_ret_%0d", i), bus.prog_ctr, 32'(5 - i));
        end
        check("ovf_cnt_end", bus.ras_count, 32'd0);
        check("ovf_sticky",  bus.ras_ovf,   32'h1);
        check("ovf_no_unf",  bus.ras_unf,   32'h0);

        cyc(0, 1, 0, 0, 10'h040, 10'h0);
        cyc(0, 0, 0, 1, 10'h0, 10'h0);
        check("unf_pc",   bus.prog_ctr,  32'h041);
        check("unf_flag", bus.ras_unf,   32'h1);
        check("unf_cnt",  bus.ras_count, 32'd0);
        do_reset();
        check("rst_ovf_clr", bus.ras_ovf, 32'h0);
        check("rst_unf_clr", bus.ras_unf, 32'h0);

        cyc(0, 0, 1, 0, 10'h060, 10'h033);
        check("both_cnt_pre", bus.ras_count, 32'd1);
        cyc(0, 0, 1, 1, 10'h077, 10'h099);
        check("both_pc",  bus.prog_ctr,  32'h033);
        check("both_cnt", bus.ras_count, 32'd0);
        cyc(0, 0, 0, 1, 10'h0, 10'h0);
        check("both_nopush_pc",  bus.prog_ctr, 32'h034);
        check("both_nopush_unf", bus.ras_unf,  32'h1);
`else
        cyc(0, 0, 1, 0, 10'h150, 10'h011);
        check("call_br_pc", bus.prog_ctr, 32'h150);
        cyc(0, 0, 0, 1, 10'h160, 10'h0);
        check("ret_br_pc",  bus.prog_ctr, 32'h160);
        cyc(1, 0, 1, 1, 10'h033, 10'h099);
        check("both_pc",  bus.prog_ctr,  32'h033);
        check("both_cnt", bus.ras_count, 32'd0);
        check("both_ovf", bus.ras_ovf,   32'h0);
        check("both_unf", bus.ras_unf,   32'h0);
        cyc(0, 0, 0, 0, 10'h0, 10'h0);
        check("both_next", bus.prog_ctr, 32'h034);
        do_reset();
        check("rst_pc", bus.prog_ctr, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
